// File: rtl/blit_cmd_fifo.sv
// blit_cmd_fifo
//   Command queue in front of the blitter command decoder. The CPU assembles a
//   104-bit command in three 32-bit staging words and pushes it with a write to
//   address 3. The entries sit in a show-ahead FIFO, and the head entry is
//   presented to the decoder.
//
// Ports
//   clock, reset         sole clock; synchronous active-high reset
//   cpu_write            one-cycle CPU write strobe
//   cpu_addr[1:0]        0/1/2 load staging s0/s1/s2, 3 push (or overflow clear)
//   cpu_wdata[31:0]      write data; on a push only [7:0] (opcode) is used, and
//                        [31]=1 turns the write into an overflow clear
//   cpu_status[31:0]     {overflow, full, empty, 24'b0, count[4:0]}
//   cmd_full             FIFO holds DEPTH entries
//   p0_cmd[103:0]        head entry {opcode[7:0], s2, s1, s0}; zero when empty
//   p0_cmd_valid         FIFO non-empty
//   cmd_next             decoder consumes the head entry
//   stall                pipeline stall; masks cmd_next

module blit_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_write,
    input  logic [1:0]    cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_status,
    output logic          cmd_full,
    output logic [103:0]  p0_cmd,
    output logic          p0_cmd_valid,
    input  logic          cmd_next,
    input  logic          stall
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]  s0_q, s1_q, s2_q;
    logic [103:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]  count_q, count_d;
    logic         ovf_q, ovf_d;

    logic         push_req, push_ok, pop, ovf_clr, empty;
    logic [4:0]   count_field;
    logic [22:0]  wdata_unused;

    // Opcode-only push payload; the remaining data bits carry nothing.
    assign wdata_unused = cpu_wdata[30:8];

    assign empty        = (count_q == '0);
    assign cmd_full     = (count_q == FULL_CNT);
    assign p0_cmd_valid = !empty;
    assign p0_cmd       = empty ? '0 : mem_q[rp_q];

    assign ovf_clr  = cpu_write && (cpu_addr == 2'd3) && cpu_wdata[31];
    assign push_req = cpu_write && (cpu_addr == 2'd3) && !cpu_wdata[31];
    assign pop      = cmd_next && p0_cmd_valid && !stall;
    // A pop in the same cycle frees the slot, so a push at full still fits.
    assign push_ok  = push_req && (!cmd_full || pop);

    assign count_field = 5'(count_q);
    assign cpu_status  = {ovf_q, cmd_full, empty, 13'b0, 11'b0, count_field};

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push_ok) wp_d = wp_q + AW'(1);
        if (pop)     rp_d = rp_q + AW'(1);
        if (push_ok && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !push_ok) count_d = count_q - (AW+1)'(1);
        if (push_req && !push_ok) ovf_d = 1'b1;
        if (ovf_clr)              ovf_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            s0_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (cpu_write && cpu_addr == 2'd0) s0_q <= cpu_wdata;
            if (cpu_write && cpu_addr == 2'd1) s1_q <= cpu_wdata;
            if (cpu_write && cpu_addr == 2'd2) s2_q <= cpu_wdata;
        end
    end

    // Storage needs no reset: it is only observed through count.
    always_ff @(posedge clock) begin
        if (!reset && push_ok)
            mem_q[wp_q] <= {cpu_wdata[7:0], s2_q, s1_q, s0_q};
    end

endmodule

// File: doc/blit_cmd_fifo.md
# blit_cmd_fifo

Command queue directly upstream of the blitter command decoder. Assembles 104-bit blitter commands from 32-bit CPU register writes, buffers them in a show-ahead FIFO, and presents the head entry as `p0_cmd`/`p0_cmd_valid`. The head entry is popped when the decoder asserts `cmd_next` in a non-stalled cycle. CPU-visible status (count, full, empty, sticky overflow) lets software throttle itself.

## Interface
Parameters:
- `DEPTH`, 16, FIFO entries; must be a power of 2, minimum 2.
- `AW`, 4, pointer width; equals log2(`DEPTH`).

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_write`  in  1  one-cycle write strobe.
- `cpu_addr`  in  2  staging word select.
- `cpu_wdata`  in  32  write data.
- `cpu_status`  out  32  {`overflow`, `full`, `empty`, 13'b0, 11'b0, `count`[4:0]}, with `overflow` at bit 31 and `count` at bits 4:0; `count` is zero-extended to 5 bits for `DEPTH` ≤ 16.
- `cmd_full`  out  1  FIFO holds `DEPTH` entries.
- `p0_cmd`  out  104  head entry: [103:96] opcode, [95:0] operands.
- `p0_cmd_valid`  out  1  FIFO non-empty.
- `cmd_next`  in  1  decoder consumes the head entry.
- `stall`  in  1  pipeline stall; while high, `cmd_next` is ignored.

## Operation
- Staging registers `s0`, `s1`, `s2` (32 bits each).
- `cpu_write` with `cpu_addr`=0, 1 or 2 loads `s0`, `s1` or `s2` respectively. The staging registers keep their values after a push, so an operand can be reused.
- `cpu_write` with `cpu_addr`=3 is a push attempt. The pushed entry is {`cpu_wdata`[7:0], `s2`, `s1`, `s0`}; `cpu_wdata`[31:8] is ignored.
- Pop = `cmd_next` & `p0_cmd_valid` & !`stall`.
- A push is accepted when count < `DEPTH`, or when a pop occurs in the same cycle.
- A rejected push drops the entry, sets the sticky `overflow` flag, and leaves pointers and count unchanged.
- `overflow` is cleared only by reset, or by a `cpu_write` to `cpu_addr`=3 with `cpu_wdata`[31]=1. This clear write is not a push.
- Storage: `DEPTH`×104 memory, write pointer `wp`, read pointer `rp` (both `AW` bits, wrap modulo `DEPTH`), and `count` (`AW`+1 bits).
- Count update: push only → +1; pop only → −1; accepted push and pop together → unchanged, both pointers advance.
- `p0_cmd` = memory[`rp`] when count > 0, else 104'h0.
- `p0_cmd_valid` = (count ≠ 0).
- `empty` = (count == 0); `full` = `cmd_full` = (count == `DEPTH`).
- `cmd_next` with an empty FIFO is a no-op. It is not an error.
- Reset values: `wp`=`rp`=0, count=0, overflow=0, `s0`=`s1`=`s2`=0. Consequently `p0_cmd_valid`=0, `p0_cmd`=0, `cmd_full`=0, `cpu_status`=32'h2000_0000 (empty only).
- Reset mid-operation discards all queued entries. A push or pop in the same cycle as reset has no effect.

## Timing
- Push → visible: an entry accepted at edge N is in memory and counted after edge N.
  - If the FIFO was empty, `p0_cmd_valid` rises and `p0_cmd` shows the entry in the cycle following edge N.
  - There is no same-cycle bypass from `cpu_wdata` to `p0_cmd`.
- Pop: when pop is true in cycle N, after edge N the next entry appears, or valid drops if the FIFO becomes empty.
  - The decoder's combinational `cmd_next` therefore sees the new head one cycle later, matching its `first_cycle` update.
- Stall: while `stall`=1, `p0_cmd` is held stable.
  - Pushes are still accepted, and `p0_cmd` holds because the head does not change.
- Throughput: one push and one pop per cycle are sustainable indefinitely, including at count = `DEPTH`.
- `cpu_status` and `cmd_full` are combinational from registered state. They reflect a push one cycle after the write cycle.

## Test plan
- Reset, then write `s0`=32'h0010_0020, `s1`=32'h0030_0040, `s2`=32'h0000_00FF, then `cpu_addr`=3 with data 8'h03 → next cycle `p0_cmd_valid`=1, `p0_cmd`=104'h03_000000FF_00300040_00100020, count=1.
- Push 3 commands with opcodes 01/02/03, then hold `cmd_next`=1 → `p0_cmd`[103:96] sequences 01, 02, 03 on consecutive cycles, then valid=0 and `p0_cmd`=0.
- Push 3 commands, hold `cmd_next`=1 with `stall`=1 for 4 cycles → no pop, `p0_cmd` constant, count=3; release `stall` → pops resume.
- Push 16 entries (`DEPTH`=16) → `cmd_full`=1, `cpu_status`[30]=1. A 17th push without a pop → dropped, `overflow`=1, count stays 16. Write 32'h8000_0000 to `cpu_addr`=3 → `overflow`=0, count still 16.
- At full, push and pop in the same cycle → push accepted, count stays 16. The popped head is the oldest entry, and the new entry emerges 16th. This also checks pointer wrap: run 40 push/pop pairs and check FIFO order.
- Assert `reset` with 5 entries queued and a simultaneous push → `p0_cmd_valid`=0, count=0, `cpu_status`=32'h2000_0000 the next cycle.
